control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 26 ++
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - datapath <-> control unit strobe and status bundle
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic        Stop;
  logic        Run;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout;
  logic        PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write;

  modport master (
    input  IR, CON, Stop,
    output Run,
    output PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout,
    output PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
    output Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write
  );

  modport slave (
    output IR, CON, Stop,
    input  Run,
    input  PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout,
    input  PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
    input  Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control FSM: fetch T0-T2, per-opcode execute T3-T7, HALT
module control_unit (
  input  logic                 clock,
  input  logic                 clear,
  control_unit_if.master       bus
);
  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD = 5'd0,  OP_LDI = 5'd1,  OP_ST = 5'd2,  OP_BRANCH = 5'd19;
  localparam logic [4:0] OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

  state_t     state;
  state_t     last_step;
  logic       stop_flag;
  logic [4:0] op;
  logic       is_alu, is_imm, is_muldiv, is_negnot, is_mem;
  logic       unused_ir_bits;

  assign op             = bus.IR[31:27];
  assign unused_ir_bits = ^bus.IR[26:0];
  assign is_alu         = (op >= 5'd3)  && (op <= 5'd11);
  assign is_imm         = (op >= 5'd12) && (op <= 5'd14);
  assign is_muldiv      = (op == 5'd15) || (op == 5'd16);
  assign is_negnot      = (op == 5'd17) || (op == 5'd18);
  assign is_mem         = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);

  // Final execute step per opcode; single-step, nop, halt and undefined end in T3.
  always_comb begin
    last_step = S_T3;
    if (is_alu || is_imm || op == OP_LDI)        last_step = S_T5;
    else if (is_muldiv || op == OP_BRANCH)       last_step = S_T6;
    else if (is_negnot || op == OP_JAL)          last_step = S_T4;
    else if (op == OP_LD || op == OP_ST)         last_step = S_T7;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_RESET;
      stop_flag <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state     <= S_T0;
          stop_flag <= 1'b0;
        end
        S_HALT: state <= S_HALT;
        default: begin
          if (state == last_step) begin
            // Stop seen on the closing edge counts toward this instruction too.
            if (op == OP_HALT || stop_flag || bus.Stop) state <= S_HALT;
            else                                       state <= S_T0;
            stop_flag <= 1'b0;
          end else begin
            state     <= state_t'(state + 4'd1);
            stop_flag <= stop_flag | bus.Stop;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.Run = (state != S_RESET) && (state != S_HALT);
    bus.PCout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0; bus.HIout = 1'b0;
    bus.LOout = 1'b0; bus.MDRout = 1'b0; bus.InPortout = 1'b0; bus.Cout = 1'b0;
    bus.PCin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
    bus.HIin = 1'b0; bus.LOin = 1'b0; bus.Zhighin = 1'b0; bus.Zlowin = 1'b0;
    bus.OutPortin = 1'b0; bus.CONin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.BAout = 1'b0; bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    case (state)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1; end
      S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_negnot) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_mem) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else begin
          case (op)
            OP_BRANCH: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
            OP_JR:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            OP_IN:     begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_OUT:    begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
            OP_MFHI:   begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MFLO:   begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_JAL:    begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
            default:   ;
          endcase
        end
      end
      S_T4: begin
        if (is_alu) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_imm || is_mem) begin
          bus.Cout = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_muldiv) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zhighin = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_negnot) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (op == OP_BRANCH) begin
          bus.PCout = 1'b1; bus.Yin = 1'b1;
        end else if (op == OP_JAL) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_imm || op == OP_LDI) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_muldiv) begin
          bus.Zlowout = 1'b1; bus.LOin = 1'b1;
        end else if (op == OP_LD || op == OP_ST) begin
          bus.Zlowout = 1'b1; bus.MARin = 1'b1;
        end else if (op == OP_BRANCH) begin
          bus.Cout = 1'b1; bus.Zlowin = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end else if (op == OP_LD) begin
          bus.Read = 1'b1; bus.MDRin = 1'b1;
        end else if (op == OP_ST) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end else if (op == OP_BRANCH) begin
          bus.Zlowout = 1'b1; bus.PCin = bus.CON;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (op == OP_ST) begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - random instruction stream against a per-opcode strobe-sequence model
module tb_control_unit;
  logic clock = 1'b0;
  logic clear = 1'b1;
  control_unit_if bus();
  control_unit dut (.clock(clock), .clear(clear), .bus(bus));
  always #5 clock = ~clock;

  typedef logic [28:0] vec_t;
  localparam vec_t RUN = vec_t'(1) << 0,  PCOUT = vec_t'(1) << 1,  ZHOUT = vec_t'(1) << 2;
  localparam vec_t ZLOUT = vec_t'(1) << 3, HIOUT = vec_t'(1) << 4,  LOOUT = vec_t'(1) << 5;
  localparam vec_t MDROUT = vec_t'(1) << 6, INPOUT = vec_t'(1) << 7, COUT = vec_t'(1) << 8;
  localparam vec_t PCIN = vec_t'(1) << 9,  MARIN = vec_t'(1) << 10, MDRIN = vec_t'(1) << 11;
  localparam vec_t IRIN = vec_t'(1) << 12, YIN = vec_t'(1) << 13,   HIIN = vec_t'(1) << 14;
  localparam vec_t LOIN = vec_t'(1) << 15, ZHIN = vec_t'(1) << 16,  ZLIN = vec_t'(1) << 17;
  localparam vec_t OUTPIN = vec_t'(1) << 18, CONIN = vec_t'(1) << 19, GRA = vec_t'(1) << 20;
  localparam vec_t GRB = vec_t'(1) << 21,  GRC = vec_t'(1) << 22,   RIN = vec_t'(1) << 23;
  localparam vec_t ROUT = vec_t'(1) << 24, BAOUT = vec_t'(1) << 25, INCPC = vec_t'(1) << 26;
  localparam vec_t READ = vec_t'(1) << 27, WRITE = vec_t'(1) << 28;
  localparam vec_t SRC = PCOUT | ZHOUT | ZLOUT | HIOUT | LOOUT | MDROUT | INPOUT | COUT | ROUT | BAOUT;

  int   checks = 0;
  int   passed = 0;
  vec_t exp_q[$];

  function automatic vec_t obs();
    return {bus.Write, bus.Read, bus.IncPC, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb,
            bus.Gra, bus.CONin, bus.OutPortin, bus.Zlowin, bus.Zhighin, bus.LOin, bus.HIin,
            bus.Yin, bus.IRin, bus.MDRin, bus.MARin, bus.PCin, bus.Cout, bus.InPortout,
            bus.MDRout, bus.LOout, bus.HIout, bus.Zlowout, bus.Zhighout, bus.PCout, bus.Run};
  endfunction

  task automatic check(input string tag, input vec_t got, input vec_t want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  task automatic check_rules(input string tag);
    vec_t o;
    o = obs();
    check({tag, "_one_src"}, vec_t'($countones(o & SRC) <= 1), vec_t'(1));
    check({tag, "_rd_wr"}, vec_t'((o & (READ | WRITE)) == (READ | WRITE)), vec_t'(0));
  endtask

  // Expected strobe sets, one per cycle, from T0 through the final execute step.
  task automatic fill(input logic [4:0] op, input logic con);
    exp_q.delete();
    exp_q.push_back(RUN | PCOUT | MARIN | INCPC | ZLIN);
    exp_q.push_back(RUN | ZLOUT | PCIN | READ | MDRIN);
    exp_q.push_back(RUN | MDROUT | IRIN);
    if (op >= 3 && op <= 11) begin
      exp_q.push_back(RUN | GRB | ROUT | YIN);
      exp_q.push_back(RUN | GRC | ROUT | ZLIN);
      exp_q.push_back(RUN | ZLOUT | GRA | RIN);
    end else if (op >= 12 && op <= 14) begin
      exp_q.push_back(RUN | GRB | ROUT | YIN);
      exp_q.push_back(RUN | COUT | ZLIN);
      exp_q.push_back(RUN | ZLOUT | GRA | RIN);
    end else begin
      case (op)
        5'd15, 5'd16: begin
          exp_q.push_back(RUN | GRA | ROUT | YIN);
          exp_q.push_back(RUN | GRB | ROUT | ZHIN | ZLIN);
          exp_q.push_back(RUN | ZLOUT | LOIN);
          exp_q.push_back(RUN | ZHOUT | HIIN);
        end
        5'd17, 5'd18: begin
          exp_q.push_back(RUN | GRB | ROUT | ZLIN);
          exp_q.push_back(RUN | ZLOUT | GRA | RIN);
        end
        5'd0, 5'd1, 5'd2: begin
          exp_q.push_back(RUN | GRB | BAOUT | YIN);
          exp_q.push_back(RUN | COUT | ZLIN);
          if (op == 5'd1) exp_q.push_back(RUN | ZLOUT | GRA | RIN);
          else            exp_q.push_back(RUN | ZLOUT | MARIN);
          if (op == 5'd0) begin
            exp_q.push_back(RUN | READ | MDRIN);
            exp_q.push_back(RUN | MDROUT | GRA | RIN);
          end else if (op == 5'd2) begin
            exp_q.push_back(RUN | GRA | ROUT | MDRIN);
            exp_q.push_back(RUN | WRITE);
          end
        end
        5'd19: begin
          exp_q.push_back(RUN | GRA | ROUT | CONIN);
          exp_q.push_back(RUN | PCOUT | YIN);
          exp_q.push_back(RUN | COUT | ZLIN);
          exp_q.push_back(RUN | ZLOUT | (con ? PCIN : vec_t'(0)));
        end
        5'd20: exp_q.push_back(RUN | GRA | ROUT | PCIN);
        5'd21: begin
          exp_q.push_back(RUN | PCOUT | GRB | RIN);
          exp_q.push_back(RUN | GRA | ROUT | PCIN);
        end
        5'd22: exp_q.push_back(RUN | INPOUT | GRA | RIN);
        5'd23: exp_q.push_back(RUN | GRA | ROUT | OUTPIN);
        5'd24: exp_q.push_back(RUN | HIOUT | GRA | RIN);
        5'd25: exp_q.push_back(RUN | LOOUT | GRA | RIN);
        default: exp_q.push_back(RUN);
      endcase
    end
  endtask

  // Entered at a falling edge; leaves at the falling edge where T0 is expected.
  task automatic reset_seq(input logic stop_level);
    clear = 1'b0;
    #1 check("rst_async", obs(), vec_t'(0));
    @(negedge clock);
    check("rst_hold", obs(), vec_t'(0));
    bus.Stop = stop_level;
    clear = 1'b1;
    #1 check("rst_release", obs(), vec_t'(0));
    @(negedge clock);
    bus.Stop = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_at, input int rst_at);
    logic [4:0] op;
    bit         stop_seen;
    op = ir[31:27];
    stop_seen = 1'b0;
    bus.IR = ir;
    bus.CON = con;
    fill(op, con);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == rst_at) begin
        reset_seq(1'b0);
        return;
      end
      bus.Stop = (i == stop_at);
      #1 check($sformatf("op%0d_step%0d", op, i), obs(), exp_q[i]);
      check_rules($sformatf("op%0d_step%0d", op, i));
      if (bus.Stop) stop_seen = 1'b1;
      @(negedge clock);
    end
    bus.Stop = 1'b0;
    if (op == 5'd27 || stop_seen) begin
      for (int k = 0; k < 12; k++) begin
        bus.Stop = 1'($urandom);
        #1 check($sformatf("halt_c%0d", k), obs(), vec_t'(0));
        @(negedge clock);
      end
      bus.Stop = 1'b0;
      reset_seq(1'($urandom));
    end
  endtask

  initial begin
    logic [31:0] ir;
    logic        con;
    int          n, stop_at, rst_at;
    bus.IR = '0;
    bus.CON = 1'b0;
    bus.Stop = 1'b0;
    #1 clear = 1'b0;
    #1 check("reset_state", obs(), vec_t'(0));
    @(negedge clock);
    reset_seq(1'b1);
    run_instr(32'h19890000, 1'b0, -1, -1);
    run_instr(32'h19890000, 1'b0, -1, 4);
    run_instr(32'h00000000, 1'b0, -1, -1);
    run_instr(32'h10000000, 1'b1, -1, -1);
    run_instr(32'h98000000, 1'b0, -1, -1);
    run_instr(32'h98000000, 1'b1, -1, -1);
    run_instr(32'h78000000, 1'b0, 4, -1);
    run_instr(32'hD8000000, 1'b0, -1, -1);
    for (int t = 0; t < 300; t++) begin
      ir  = $urandom;
      con = 1'($urandom);
      fill(ir[31:27], con);
      n = exp_q.size();
      stop_at = ($urandom_range(7) == 0) ? int'($urandom_range(n - 2)) : -1;
      rst_at  = ($urandom_range(15) == 0) ? int'($urandom_range(n - 1)) : -1;
      run_instr(ir, con, stop_at, rst_at);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
endmodule
